// File: rtl/clint_if.sv
// Wishbone slave bus bundle for the core-local interruptor (CLINT).
// Signal names are seen from the slave side: _i are slave inputs and _o are slave outputs.
interface clint_if #(
  parameter int DATA_SIZE = 64
) ();
  logic                   wb_cyc_i;
  logic                   wb_stb_i;
  logic                   wb_we_i;
  logic [15:0]            wb_addr_i;
  logic [DATA_SIZE/8-1:0] wb_sel_i;
  logic [DATA_SIZE-1:0]   wb_dat_i;
  logic [DATA_SIZE-1:0]   wb_dat_o;
  logic                   wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/clint.sv
// Core-local interruptor: a Wishbone slave that owns msip, mtime (prescaled) and mtimecmp.
// Optional byte-lane write masking is enabled by defining CLINT_SEL_EN.
module clint #(
  parameter int DATA_SIZE             = 64,
  parameter int CLOCK_CYCLES_PER_TICK = 2
) (
  input  logic        clock,
  input  logic        reset,
  clint_if.slave      wb,
  output logic        msip,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp
);

  localparam int NB = DATA_SIZE / 8;
  localparam int PW = (CLOCK_CYCLES_PER_TICK > 1) ? $clog2(CLOCK_CYCLES_PER_TICK) : 1;
  localparam logic [PW-1:0] PRESC_LAST    = PW'(CLOCK_CYCLES_PER_TICK - 1);
  localparam logic [15:0]   MSIP_ADDR     = 16'h0000;
  localparam logic [15:0]   MTIMECMP_ADDR = 16'h4000;
  localparam logic [15:0]   MTIME_ADDR    = 16'hBFF8;

  typedef enum logic {
    ST_IDLE,
    ST_ACK
  } state_e;

  state_e               state_q;
  logic                 ack_q;
  logic [DATA_SIZE-1:0] dat_q;
  logic [PW-1:0]        presc_q, presc_d;
  logic                 msip_q, msip_d;
  logic [63:0]          mtime_q, mtime_d;
  logic [63:0]          mtimecmp_q, mtimecmp_d;

  logic                 tick;
  logic                 req;
  logic                 wr_commit;
  logic [15:0]          addr_word;
  logic                 hit_msip, hit_mtimecmp, hit_mtime;
  logic                 hi_half;
  logic [NB-1:0]        lane_en;
  logic [63:0]          wdata64;
  logic [7:0]           be64;
  logic [63:0]          rdata64;
  logic [DATA_SIZE-1:0] rdata_bus;

  // Drop the byte-offset bits; in 32-bit mode bit 2 then selects the half of a 64-bit register.
  assign addr_word    = wb.wb_addr_i & ~16'(NB - 1);
  assign hit_msip     = (addr_word == MSIP_ADDR);
  assign hit_mtimecmp = ((addr_word & ~16'h0007) == MTIMECMP_ADDR);
  assign hit_mtime    = ((addr_word & ~16'h0007) == MTIME_ADDR);
  assign hi_half      = addr_word[2];

  assign req       = wb.wb_cyc_i & wb.wb_stb_i;
  assign wr_commit = (state_q == ST_IDLE) & req & wb.wb_we_i;
  assign tick      = (presc_q == PRESC_LAST);

`ifdef CLINT_SEL_EN
  assign lane_en = wb.wb_sel_i;
`else
  logic unused_sel;
  assign unused_sel = ^wb.wb_sel_i;
  assign lane_en    = '1;
`endif

  // Present every access as a 64-bit write with per-byte enables so one merge path serves both widths.
  generate
    if (DATA_SIZE == 64) begin : g_bus64
      assign wdata64   = wb.wb_dat_i;
      assign be64      = lane_en;
      assign rdata_bus = rdata64;
    end else begin : g_bus32
      assign wdata64   = {wb.wb_dat_i, wb.wb_dat_i};
      assign be64      = hi_half ? {lane_en, 4'b0000} : {4'b0000, lane_en};
      assign rdata_bus = hi_half ? rdata64[63:32] : rdata64[31:0];
    end
  endgenerate

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                              input logic [63:0] new_v,
                                              input logic [7:0]  be);
    logic [63:0] res;
    for (int b = 0; b < 8; b++) begin
      res[b*8 +: 8] = be[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return res;
  endfunction

  // NOTE: every signal written here gets a default first so no latch can be inferred.
  always_comb begin
    presc_d    = tick ? '0 : presc_q + PW'(1);
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    rdata64    = '0;

    // A bus write to mtime overrides the same-edge increment; the other half keeps its value.
    if (wr_commit) begin
      if (hit_msip && be64[0]) msip_d     = wdata64[0];
      if (hit_mtimecmp)        mtimecmp_d = merge_bytes(mtimecmp_q, wdata64, be64);
      if (hit_mtime)           mtime_d    = merge_bytes(mtime_q, wdata64, be64);
    end

    if (hit_msip)          rdata64 = {63'd0, msip_q};
    else if (hit_mtimecmp) rdata64 = mtimecmp_q;
    else if (hit_mtime)    rdata64 = mtime_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      presc_q    <= '0;
      msip_q     <= 1'b0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
    end else begin
      presc_q    <= presc_d;
      msip_q     <= msip_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      unique case (state_q)
        ST_IDLE: begin
          if (req) begin
            ack_q   <= 1'b1;
            dat_q   <= wb.wb_we_i ? '0 : rdata_bus;
            state_q <= ST_ACK;
          end
        end
        ST_ACK: begin
          ack_q   <= 1'b0;
          dat_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: begin
          ack_q   <= 1'b0;
          dat_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign msip        = msip_q;
  assign mtime       = mtime_q;
  assign mtimecmp    = mtimecmp_q;

endmodule

// File: tb/tb_clint.sv
// Directed bench for clint: a 64-bit DUT with a tick every 2 cycles, a 32-bit DUT with a slow tick,
// and a 64-bit DUT that ticks on every cycle.
module tb_clint;

  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   cyc;

  clint_if #(.DATA_SIZE(64)) bus64 ();
  clint_if #(.DATA_SIZE(32)) bus32 ();
  clint_if #(.DATA_SIZE(64)) bus1 ();

  logic        msip64, msip32, msip1;
  logic [63:0] mtime64, mtime32, mtime1;
  logic [63:0] mtimecmp64, mtimecmp32, mtimecmp1;

  clint #(.DATA_SIZE(64), .CLOCK_CYCLES_PER_TICK(2)) u_clint64 (
    .clock(clock), .reset(reset), .wb(bus64),
    .msip(msip64), .mtime(mtime64), .mtimecmp(mtimecmp64)
  );

  clint #(.DATA_SIZE(32), .CLOCK_CYCLES_PER_TICK(4096)) u_clint32 (
    .clock(clock), .reset(reset), .wb(bus32),
    .msip(msip32), .mtime(mtime32), .mtimecmp(mtimecmp32)
  );

  clint #(.DATA_SIZE(64), .CLOCK_CYCLES_PER_TICK(1)) u_clint1 (
    .clock(clock), .reset(reset), .wb(bus1),
    .msip(msip1), .mtime(mtime1), .mtimecmp(mtimecmp1)
  );

  always #5 clock = ~clock;

  // Edges since reset release; with a 2-cycle tick the 64-bit DUT increments on even counts.
  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_idle();
    bus64.wb_cyc_i = 0; bus64.wb_stb_i = 0; bus64.wb_we_i = 0;
    bus64.wb_addr_i = '0; bus64.wb_sel_i = '0; bus64.wb_dat_i = '0;
    bus32.wb_cyc_i = 0; bus32.wb_stb_i = 0; bus32.wb_we_i = 0;
    bus32.wb_addr_i = '0; bus32.wb_sel_i = '0; bus32.wb_dat_i = '0;
    bus1.wb_cyc_i = 0; bus1.wb_stb_i = 0; bus1.wb_we_i = 0;
    bus1.wb_addr_i = '0; bus1.wb_sel_i = '0; bus1.wb_dat_i = '0;
  endtask

  // One transfer; lat = edges until ack (-1 on timeout), ack_after = ack one edge after the ack cycle.
  task automatic xfer(input bit narrow, input bit we, input logic [15:0] addr,
                      input logic [7:0] sel, input logic [63:0] wdat,
                      output logic [63:0] rdat, output int lat, output logic ack_after);
    logic ack;
    if (narrow) begin
      bus32.wb_cyc_i = 1; bus32.wb_stb_i = 1; bus32.wb_we_i = we;
      bus32.wb_addr_i = addr; bus32.wb_sel_i = sel[3:0]; bus32.wb_dat_i = wdat[31:0];
    end else begin
      bus64.wb_cyc_i = 1; bus64.wb_stb_i = 1; bus64.wb_we_i = we;
      bus64.wb_addr_i = addr; bus64.wb_sel_i = sel; bus64.wb_dat_i = wdat;
    end
    lat  = -1;
    rdat = '0;
    for (int i = 1; i <= 4; i++) begin
      step();
      ack = narrow ? bus32.wb_ack_o : bus64.wb_ack_o;
      if (ack) begin
        lat  = i;
        rdat = narrow ? {32'd0, bus32.wb_dat_o} : bus64.wb_dat_o;
        break;
      end
    end
    bus_idle();
    step();
    ack_after = narrow ? bus32.wb_ack_o : bus64.wb_ack_o;
  endtask

  task automatic wr(input string tag, input bit narrow, input logic [15:0] addr,
                    input logic [7:0] sel, input logic [63:0] data);
    logic [63:0] rdat;
    int          lat;
    logic        ack_after;
    xfer(narrow, 1'b1, addr, sel, data, rdat, lat, ack_after);
    check({tag, "_lat"}, 64'(lat), 64'd1);
    check({tag, "_ackdrop"}, {63'd0, ack_after}, 64'd0);
    check({tag, "_wdat0"}, rdat, 64'd0);
  endtask

  task automatic rd(input string tag, input bit narrow, input logic [15:0] addr,
                    input logic [63:0] exp);
    logic [63:0] rdat;
    int          lat;
    logic        ack_after;
    xfer(narrow, 1'b0, addr, 8'hFF, 64'd0, rdat, lat, ack_after);
    check({tag, "_lat"}, 64'(lat), 64'd1);
    check({tag, "_data"}, rdat, exp);
  endtask

  // Leave the bench so the next sampled edge is an even (tick) edge of the 64-bit DUT.
  task automatic align_tick();
    while (cyc % 2 != 1) step();
  endtask

  initial begin
    int          nack;
    logic [63:0] sel_exp;

    reset = 1'b1;
    bus_idle();
    step();
    step();
    check("rst_msip", {63'd0, msip64}, 64'd0);
    check("rst_mtime", mtime64, 64'd0);
    check("rst_mtimecmp", mtimecmp64, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_ack", {63'd0, bus64.wb_ack_o}, 64'd0);
    check("rst_dat", bus64.wb_dat_o, 64'd0);

    reset = 1'b0;
    repeat (10) step();
    check("count_tick2", mtime64, 64'd5);
    check("count_tick1", mtime1, 64'd10);
    check("count_tick4096", mtime32, 64'd0);

    // Handshake and mtimecmp
    wr("cmp_wr", 1'b0, 16'h4000, 8'hFF, 64'h100);
    check("cmp_val", mtimecmp64, 64'h100);
    rd("cmp_rd", 1'b0, 16'h4000, 64'h100);

    // Held strobe: ack on alternate edges
    bus64.wb_cyc_i = 1; bus64.wb_stb_i = 1; bus64.wb_we_i = 0; bus64.wb_addr_i = 16'h4000;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("hold_ack%0d", i), {63'd0, bus64.wb_ack_o}, (i % 2 == 0) ? 64'd1 : 64'd0);
    end
    bus_idle();

    // msip and unmapped
    wr("msip_wr1", 1'b0, 16'h0000, 8'hFF, 64'hFFFF_FFFF);
    check("msip_set", {63'd0, msip64}, 64'd1);
    rd("msip_rd1", 1'b0, 16'h0000, 64'd1);
    wr("msip_wr0", 1'b0, 16'h0000, 8'hFF, 64'd0);
    check("msip_clr", {63'd0, msip64}, 64'd0);
    rd("unmapped_rd", 1'b0, 16'h1234, 64'd0);

    // cyc low with stb high is not a request
    bus64.wb_cyc_i = 0; bus64.wb_stb_i = 1; bus64.wb_addr_i = 16'h4000;
    nack = 0;
    repeat (3) begin
      step();
      nack += int'(bus64.wb_ack_o);
    end
    bus_idle();
    check("nocyc_ack", 64'(nack), 64'd0);

    // mtime wrap
    align_tick();
    wr("wrap_wr", 1'b0, 16'hBFF8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    check("wrap_hold", mtime64, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    check("wrap_zero", mtime64, 64'd0);

    // Write on a tick edge wins; prescaler phase is unaffected
    align_tick();
    wr("coll_wr", 1'b0, 16'hBFF8, 8'hFF, 64'h50);
    check("coll_val", mtime64, 64'h50);
    step();
    check("coll_next", mtime64, 64'h51);
    step();
    rd("mtime_rd", 1'b0, 16'hBFFC, 64'h51);
    check("mtime_after_rd", mtime64, 64'h52);

    // Byte-lane select
    wr("sel_pre", 1'b0, 16'h4000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wr("sel_wr", 1'b0, 16'h4000, 8'h01, 64'hAA);
`ifdef CLINT_SEL_EN
    sel_exp = 64'hFFFF_FFFF_FFFF_FFAA;
`else
    sel_exp = 64'h0000_0000_0000_00AA;
`endif
    check("sel_val", mtimecmp64, sel_exp);

    // 32-bit half-word accesses
    wr("h_lo", 1'b1, 16'hBFF8, 8'hFF, 64'hFFFF_FFF0);
    check("h_lo_val", mtime32, 64'h0000_0000_FFFF_FFF0);
    wr("h_hi", 1'b1, 16'hBFFC, 8'hFF, 64'h1);
    check("h_hi_val", mtime32, 64'h0000_0001_FFFF_FFF0);
    rd("h_rd_lo", 1'b1, 16'hBFF8, 64'hFFFF_FFF0);
    rd("h_rd_hi", 1'b1, 16'hBFFC, 64'h1);
    wr("h_cmp_hi", 1'b1, 16'h4004, 8'hFF, 64'h1234_5678);
    check("h_cmp_val", mtimecmp32, 64'h1234_5678_FFFF_FFFF);
    rd("h_cmp_rd_lo", 1'b1, 16'h4000, 64'hFFFF_FFFF);
    wr("h_msip_unmap", 1'b1, 16'h0004, 8'hFF, 64'h1);
    check("h_msip_unmap_val", {63'd0, msip32}, 64'd0);
    wr("h_msip", 1'b1, 16'h0000, 8'hFF, 64'h1);
    check("h_msip_val", {63'd0, msip32}, 64'd1);

    // Reset asserted during Ack
    wr("pre_rst_msip", 1'b0, 16'h0000, 8'hFF, 64'h1);
    bus64.wb_cyc_i = 1; bus64.wb_stb_i = 1; bus64.wb_we_i = 0; bus64.wb_addr_i = 16'h0000;
    step();
    check("mid_ack", {63'd0, bus64.wb_ack_o}, 64'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_ack", {63'd0, bus64.wb_ack_o}, 64'd0);
    check("mid_rst_dat", bus64.wb_dat_o, 64'd0);
    check("mid_rst_msip", {63'd0, msip64}, 64'd0);
    check("mid_rst_mtime", mtime64, 64'd0);
    check("mid_rst_cmp", mtimecmp64, 64'hFFFF_FFFF_FFFF_FFFF);
    check("mid_rst_msip32", {63'd0, msip32}, 64'd0);
    bus_idle();
    #3;
    reset = 1'b0;
    step();
    check("post_rst_ack", {63'd0, bus64.wb_ack_o}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
